uart_tx_arbiter: RTL

Round-robin scheduler that shares one `uart_transmitter` between four byte-producing requesters. It picks one pending request, latches its byte, and issues a single-cycle `Tx_WR` to the transmitter. It then tracks `Tx_BUSY` through accept and completion before serving the next requester. It sits between the encoder-side producers and the transmitter inside the UART link, and flags a transmitter that never accepts a write.

---
 rtl/uart_tx_arbiter.sv | 135 +++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART transmitter between four byte producers.
// Issues one Tx_WR per grant, then follows Tx_BUSY through accept and completion.
module uart_tx_arbiter #(
  parameter int unsigned ACCEPT_TIMEOUT = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic [3:0]  req,
  input  logic [31:0] req_data,
  input  logic        Tx_BUSY,
  output logic [3:0]  grant,
  output logic [1:0]  grant_id,
  output logic [7:0]  Tx_DATA,
  output logic        Tx_WR,
  output logic        Tx_EN,
  output logic        arb_busy,
  output logic        timeout_err
);

  localparam int unsigned NUM_REQ = 4;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_e;

  state_e      state_q, state_d;
  logic [1:0]  ptr_q, ptr_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_wr_q, tx_wr_d;
  logic        tx_en_q, tx_en_d;
  logic [3:0]  grant_q, grant_d;
  logic [1:0]  grant_id_q, grant_id_d;
  logic        arb_busy_q, arb_busy_d;
  logic        timeout_err_q, timeout_err_d;

  logic [NUM_REQ-1:0][7:0] req_bytes;
  logic                    found;
  logic [1:0]              win;
  logic [1:0]              idx;

  assign req_bytes = req_data;

  // First requester at or after ptr, wrapping mod 4.
  always_comb begin
    found = 1'b0;
    win   = ptr_q;
    idx   = ptr_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = ptr_q + 2'(k);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    cnt_d         = cnt_q;
    tx_data_d     = tx_data_q;
    tx_wr_d       = 1'b0;
    grant_d       = 4'b0000;
    grant_id_d    = grant_id_q;
    timeout_err_d = timeout_err_q;
    case (state_q)
      IDLE: begin
        // Strobe and grant are registered here so they are high during ISSUE.
        if (enable && !Tx_BUSY && found) begin
          state_d    = ISSUE;
          tx_data_d  = req_bytes[win];
          tx_wr_d    = 1'b1;
          grant_d    = 4'b0001 << win;
          grant_id_d = win;
          ptr_d      = win + 2'd1;
        end
      end
      ISSUE: begin
        state_d = WAIT_BUSY;
        cnt_d   = 8'd0;
      end
      WAIT_BUSY: begin
        if (Tx_BUSY) begin
          state_d = WAIT_DONE;
        end else if (cnt_q == 8'(ACCEPT_TIMEOUT - 1)) begin
          state_d       = IDLE;
          timeout_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      WAIT_DONE: begin
        if (!Tx_BUSY) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    tx_en_d    = enable || (state_d != IDLE);
    arb_busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      ptr_q         <= 2'd0;
      cnt_q         <= 8'd0;
      tx_data_q     <= 8'h00;
      tx_wr_q       <= 1'b0;
      tx_en_q       <= 1'b0;
      grant_q       <= 4'b0000;
      grant_id_q    <= 2'd0;
      arb_busy_q    <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      cnt_q         <= cnt_d;
      tx_data_q     <= tx_data_d;
      tx_wr_q       <= tx_wr_d;
      tx_en_q       <= tx_en_d;
      grant_q       <= grant_d;
      grant_id_q    <= grant_id_d;
      arb_busy_q    <= arb_busy_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign grant       = grant_q;
  assign grant_id    = grant_id_q;
  assign Tx_DATA     = tx_data_q;
  assign Tx_WR       = tx_wr_q;
  assign Tx_EN       = tx_en_q;
  assign arb_busy    = arb_busy_q;
  assign timeout_err = timeout_err_q;

endmodule
